// File: rtl/counter_spi_slave_pkg.sv
// Shared constants for the counter SPI slave: channel count, FSM encoding
// and sizing helpers for the frame and bit counter.
package counter_spi_slave_pkg;

    localparam int NUM_CH = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    function automatic int frame_bits(input int width);
        return NUM_CH * width;
    endfunction

    // Counter must be able to hold FRAME_BITS itself, not just FRAME_BITS-1.
    function automatic int cnt_width(input int frame);
        return $clog2(frame + 1);
    endfunction

endpackage

// File: rtl/counter_spi_slave_sync.sv
// Multi-flop synchroniser for an asynchronous pin, followed by a history flop
// that turns the synchronised level into single-cycle rise/fall pulses.
module sync_edge #(
    parameter int       sync_stages = 2,
    parameter bit       idle        = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [sync_stages-1:0] sync;
    logic                   hist;

    // Resetting to the idle level keeps reset release from looking like an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= {sync_stages{idle}};
            hist <= idle;
        end else begin
            sync <= {sync[sync_stages-2:0], din};
            hist <= sync[sync_stages-1];
        end
    end

    assign level = sync[sync_stages-1];
    assign rise  = level & ~hist;
    assign fall  = ~level & hist;

endmodule

// File: rtl/counter_spi_slave.sv
// SPI mode-0 slave that snapshots four channel counters on chip-select fall
// and shifts them out MSB first, channel 0 first.
module counter_spi_slave
    import counter_spi_slave_pkg::*;
#(
    parameter int size        = 8,
    parameter int sync_stages = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [size-1:0] count0,
    input  logic [size-1:0] count1,
    input  logic [size-1:0] count2,
    input  logic [size-1:0] count3,
    input  logic            ss_n,
    input  logic            sck,
    output logic            miso,
    output logic            miso_oe,
    output logic            frame_done,
    output logic            frame_abort
);

    localparam int FRAME_BITS = frame_bits(size);
    localparam int CW         = cnt_width(FRAME_BITS);
    localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_BITS - 1);

    logic                  ss_level, ss_rise, ss_fall;
    logic                  sck_level, sck_rise, sck_fall;
    logic [1:0]            state;
    logic [FRAME_BITS-1:0] shreg;
    logic [CW-1:0]         bitcnt;

    sync_edge #(.sync_stages(sync_stages), .idle(1'b1)) u_ss_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (ss_n),
        .level (ss_level),
        .rise  (ss_rise),
        .fall  (ss_fall)
    );

    sync_edge #(.sync_stages(sync_stages), .idle(1'b0)) u_sck_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (sck),
        .level (sck_level),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            shreg       <= '0;
            bitcnt      <= '0;
            miso        <= 1'b0;
            miso_oe     <= 1'b0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            miso        <= (state != ST_IDLE) && !ss_level && shreg[FRAME_BITS-1];
            case (state)
                ST_IDLE: begin
                    if (ss_fall) begin
                        shreg   <= {count0, count1, count2, count3};
                        bitcnt  <= '0;
                        miso_oe <= 1'b1;
                        state   <= ST_SHIFT;
                    end
                end
                // ss_n release outranks any sck edge seen in the same cycle.
                ST_SHIFT: begin
                    if (ss_rise) begin
                        frame_abort <= 1'b1;
                        miso_oe     <= 1'b0;
                        state       <= ST_IDLE;
                    end else if (sck_rise && sck_level) begin
                        bitcnt <= bitcnt + CW'(1);
                        if (bitcnt == LAST_BIT) begin
                            state <= ST_DONE;
                        end
                    end else if (sck_fall) begin
                        shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
                    end
                end
                // Counter stays saturated at FRAME_BITS; extra clocks shift out zeros.
                ST_DONE: begin
                    if (ss_rise) begin
                        frame_done <= 1'b1;
                        miso_oe    <= 1'b0;
                        state      <= ST_IDLE;
                    end else if (sck_fall) begin
                        shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
                    end
                end
                default: begin
                    miso_oe <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_spi_slave.sv
// Directed bench for counter_spi_slave: table of SPI frames plus hand-written
// reset-mid-frame and idle-noise sequences.
module tb_counter_spi_slave;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] count0 = '0, count1 = '0, count2 = '0, count3 = '0;
    logic       ss_n = 1'b1;
    logic       sck  = 1'b0;
    logic       miso, miso_oe, frame_done, frame_abort;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int abort_cnt = 0;

    counter_spi_slave #(.size(8), .sync_stages(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .count0      (count0),
        .count1      (count1),
        .count2      (count2),
        .count3      (count3),
        .ss_n        (ss_n),
        .sck         (sck),
        .miso        (miso),
        .miso_oe     (miso_oe),
        .frame_done  (frame_done),
        .frame_abort (frame_abort)
    );

    always #5 clk = ~clk;

    // Counting high cycles also catches pulses wider than one cycle.
    always @(negedge clk) begin
        if (frame_done)  done_cnt  <= done_cnt + 1;
        if (frame_abort) abort_cnt <= abort_cnt + 1;
    end

    typedef struct {
        logic [7:0]  c0, c1, c2, c3;
        int          nclk;
        int          chg_at;
        logic [7:0]  chg_val;
        logic [63:0] exp_rx;
        int          exp_done;
        int          exp_abort;
    } frame_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Master side: sample miso as sck rises, change data on falls.
    task automatic run_frame(input frame_t f, input string tag);
        logic [63:0] rx;
        int d0, a0;
        rx = '0;
        d0 = done_cnt;
        a0 = abort_cnt;
        @(negedge clk);
        count0 = f.c0; count1 = f.c1; count2 = f.c2; count3 = f.c3;
        ss_n = 1'b0;
        wait_clk(10);
        check({tag, "_oe_start"}, {63'd0, miso_oe}, 64'd1);
        for (int i = 0; i < f.nclk; i++) begin
            if (i == f.chg_at) count0 = f.chg_val;
            sck = 1'b1;
            rx = {rx[62:0], miso};
            wait_clk(5);
            sck = 1'b0;
            wait_clk(5);
        end
        check({tag, "_oe_end"}, {63'd0, miso_oe}, 64'd1);
        ss_n = 1'b1;
        wait_clk(10);
        check({tag, "_rx"}, rx, f.exp_rx);
        check({tag, "_oe_after"}, {63'd0, miso_oe}, 64'd0);
        check({tag, "_done"}, 64'(done_cnt - d0), 64'(f.exp_done));
        check({tag, "_abort"}, 64'(abort_cnt - a0), 64'(f.exp_abort));
    endtask

    frame_t tbl[7];
    frame_t good;

    initial begin
        tbl[0] = '{8'hA5, 8'h3C, 8'h01, 8'hFF, 32, -1, 8'h00, 64'hA53C01FF,   1, 0};
        tbl[1] = '{8'h00, 8'hFF, 8'h80, 8'h01, 32, -1, 8'h00, 64'h00FF8001,   1, 0};
        tbl[2] = '{8'h10, 8'h00, 8'h00, 8'h00,  8,  3, 8'h20, 64'h10,         0, 1};
        tbl[3] = '{8'h20, 8'h00, 8'h00, 8'h00,  8, -1, 8'h00, 64'h20,         0, 1};
        tbl[4] = '{8'hA5, 8'h3C, 8'h01, 8'hFF, 12, -1, 8'h00, 64'hA53,        0, 1};
        tbl[5] = '{8'hA5, 8'h3C, 8'h01, 8'hFF, 32, -1, 8'h00, 64'hA53C01FF,   1, 0};
        tbl[6] = '{8'hA5, 8'h3C, 8'h01, 8'hFF, 40, -1, 8'h00, 64'hA53C01FF00, 1, 0};
        good   = tbl[0];

        wait_clk(3);
        rst = 1'b0;
        @(negedge clk);
        check("reset_miso",  {63'd0, miso},        64'd0);
        check("reset_oe",    {63'd0, miso_oe},     64'd0);
        check("reset_done",  {63'd0, frame_done},  64'd0);
        check("reset_abort", {63'd0, frame_abort}, 64'd0);
        wait_clk(5);

        for (int k = 0; k < 7; k++) begin
            run_frame(tbl[k], $sformatf("vec%0d", k));
        end

        // Reset mid-frame: ss_n released together with rst so no new fall is seen.
        begin
            int d0, a0;
            d0 = done_cnt;
            a0 = abort_cnt;
            count0 = 8'hA5; count1 = 8'h3C; count2 = 8'h01; count3 = 8'hFF;
            ss_n = 1'b0;
            wait_clk(10);
            for (int i = 0; i < 5; i++) begin
                sck = 1'b1; wait_clk(5);
                sck = 1'b0; wait_clk(5);
            end
            rst = 1'b1;
            ss_n = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("rstmid_miso", {63'd0, miso},    64'd0);
            check("rstmid_oe",   {63'd0, miso_oe}, 64'd0);
            wait_clk(10);
            check("rstmid_oe_later", {63'd0, miso_oe},         64'd0);
            check("rstmid_done",     64'(done_cnt - d0),       64'd0);
            check("rstmid_abort",    64'(abort_cnt - a0),      64'd0);
            run_frame(good, "after_rst");
        end

        // Idle noise: sck toggling with ss_n high must not wake the slave.
        begin
            int d0, a0;
            logic seen_oe, seen_miso;
            d0 = done_cnt;
            a0 = abort_cnt;
            seen_oe = 1'b0;
            seen_miso = 1'b0;
            for (int i = 0; i < 10; i++) begin
                sck = 1'b1; wait_clk(5);
                seen_oe |= miso_oe; seen_miso |= miso;
                sck = 1'b0; wait_clk(5);
                seen_oe |= miso_oe; seen_miso |= miso;
            end
            wait_clk(5);
            check("noise_oe",    {63'd0, seen_oe},   64'd0);
            check("noise_miso",  {63'd0, seen_miso}, 64'd0);
            check("noise_done",  64'(done_cnt - d0),  64'd0);
            check("noise_abort", 64'(abort_cnt - a0), 64'd0);
            run_frame(good, "after_noise");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
